// File: rtl/spi_master_ctrl.sv
// CPU-bus SPI master (mode 0, MSB first) with a programmable clock divider.
// A DATA write starts an 8-bit transfer; STATUS reports busy/done to the polling CPU.
module spi_master_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd24,
  parameter logic       CS_RESET  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rwb,
  input  logic [1:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       sd_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    CLK_LO,
    CLK_HI
  } state_t;

  state_t     state;
  logic [7:0] div_reg;
  logic [7:0] divcnt;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic [7:0] rx;
  logic       miso_latch;
  logic       busy;
  logic       done;

  logic       wr_en;
  logic       rd_en;
  logic [7:0] shifted;

  assign wr_en   = cs && !rwb;
  assign rd_en   = cs && rwb;
  assign shifted = {shreg[6:0], miso_latch};

  always_comb begin
    data_o = 8'h00;
    if (rd_en) begin
      case (addr)
        REG_DATA:   data_o = rx;
        REG_STATUS: data_o = {6'b0, done, busy};
        REG_CTRL:   data_o = {7'b0, sd_cs};
        REG_DIV:    data_o = div_reg;
        default:    data_o = 8'h00;
      endcase
    end
  end

  // The done-clear from a DATA read comes first so that a same-cycle completion wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_reg    <= DIV_RESET;
      divcnt     <= 8'd0;
      bitcnt     <= 3'd0;
      shreg      <= 8'd0;
      rx         <= 8'd0;
      miso_latch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sd_cs      <= CS_RESET;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b1;
    end else begin
      if (wr_en && addr == REG_CTRL)
        sd_cs <= data_i[0];
      if (wr_en && addr == REG_DIV && !busy)
        div_reg <= data_i;
      if (rd_en && addr == REG_DATA)
        done <= 1'b0;

      case (state)
        IDLE: begin
          spi_clk  <= 1'b0;
          spi_mosi <= 1'b1;
          if (wr_en && addr == REG_DATA) begin
            shreg    <= data_i;
            spi_mosi <= data_i[7];
            bitcnt   <= 3'd0;
            divcnt   <= 8'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= CLK_LO;
          end
        end

        CLK_LO: begin
          if (divcnt == div_reg) begin
            spi_clk    <= 1'b1;
            miso_latch <= spi_miso;
            divcnt     <= 8'd0;
            state      <= CLK_HI;
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end

        // Falling edge: shift in the latched MISO bit and present the next MOSI bit.
        CLK_HI: begin
          if (divcnt == div_reg) begin
            spi_clk <= 1'b0;
            shreg   <= shifted;
            divcnt  <= 8'd0;
            if (bitcnt == 3'd7) begin
              rx       <= shifted;
              busy     <= 1'b0;
              done     <= 1'b1;
              spi_mosi <= 1'b1;
              state    <= IDLE;
            end else begin
              bitcnt   <= bitcnt + 3'd1;
              spi_mosi <= shifted[7];
              state    <= CLK_LO;
            end
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
